// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shift register with a valid/ready load handshake,
// bit-rate enable, framing outputs and gapless back-to-back word streaming.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter bit   LSB_FIRST  = 1'b0,
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             LOAD_VALID,
  output logic             LOAD_READY,
  input  logic [WIDTH-1:0] D,
  input  logic             SHIFT_EN,
  output logic             Q0,
  output logic             Q_VALID,
  output logic             BUSY,
  output logic             DONE
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             last_s;
  logic             accept_s;

  // Framing outputs and next-state logic; a load on the last bit keeps the stream gapless
  always_comb begin
    last_s     = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX) && SHIFT_EN;
    LOAD_READY = !RST && ((state_q == ST_IDLE) || last_s);
    accept_s   = LOAD_READY && LOAD_VALID;
    DONE       = last_s;
    BUSY       = (state_q == ST_SHIFT);
    Q_VALID    = (state_q == ST_SHIFT);
    if (state_q == ST_SHIFT) begin
      Q0 = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
    end else begin
      Q0 = IDLE_LEVEL;
    end

    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept_s) begin
      state_d = ST_SHIFT;
      shreg_d = D;
      cnt_d   = {CW{1'b0}};
    end else if ((state_q == ST_SHIFT) && SHIFT_EN) begin
      if (LSB_FIRST) begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end else begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end
      // The counter parks at the last index until the next load clears it
      if (last_s) begin
        state_d = ST_IDLE;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers; reset discards any word in flight immediately
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      shreg_q <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a word/bit-index model plus literal sequences.
module tb_piso_serializer;
  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         LOAD_VALID = 1'b0;
  logic [W-1:0] D = 8'h00;
  logic         SHIFT_EN = 1'b0;

  logic msb_rdy, msb_q0, msb_qv, msb_busy, msb_done;
  logic lsb_rdy, lsb_q0, lsb_qv, lsb_busy, lsb_done;

  int total = 0;
  int bad   = 0;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(msb_rdy), .D(D),
    .SHIFT_EN(SHIFT_EN), .Q0(msb_q0), .Q_VALID(msb_qv), .BUSY(msb_busy), .DONE(msb_done)
  );

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
    .CLK(CLK), .RST(RST), .LOAD_VALID(LOAD_VALID), .LOAD_READY(lsb_rdy), .D(D),
    .SHIFT_EN(SHIFT_EN), .Q0(lsb_q0), .Q_VALID(lsb_qv), .BUSY(lsb_busy), .DONE(lsb_done)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Behavioural model: the word in flight and the index of the bit on the wire
  logic [W-1:0] mdl_word = 8'h00;
  int           mdl_idx  = 0;
  bit           mdl_busy = 1'b0;
  bit           mdl_acc  = 1'b0;
  bit           mdl_rdy;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      mdl_busy = 1'b0;
      mdl_acc  = 1'b0;
    end else begin
      mdl_rdy = !mdl_busy || ((mdl_idx == W - 1) && SHIFT_EN);
      mdl_acc = mdl_rdy && LOAD_VALID;
      if (mdl_acc) begin
        mdl_word = D;
        mdl_idx  = 0;
        mdl_busy = 1'b1;
      end else if (mdl_busy && SHIFT_EN) begin
        if (mdl_idx == W - 1) mdl_busy = 1'b0;
        else mdl_idx++;
      end
    end
  end

  bit e_done, e_rdy, e_msb, e_lsb;

  always @(negedge CLK) begin
    e_done = mdl_busy && (mdl_idx == W - 1) && SHIFT_EN && !RST;
    e_rdy  = !RST && (!mdl_busy || e_done);
    e_msb  = mdl_busy ? mdl_word[W-1-mdl_idx] : 1'b1;
    e_lsb  = mdl_busy ? mdl_word[mdl_idx] : 1'b1;
    chk("msb_q0", msb_q0, e_msb);
    chk("msb_qvalid", msb_qv, mdl_busy);
    chk("msb_busy", msb_busy, mdl_busy);
    chk("msb_done", msb_done, e_done);
    chk("msb_ready", msb_rdy, e_rdy);
    chk("lsb_q0", lsb_q0, e_lsb);
    chk("lsb_qvalid", lsb_qv, mdl_busy);
    chk("lsb_busy", lsb_busy, mdl_busy);
    chk("lsb_done", lsb_done, e_done);
    chk("lsb_ready", lsb_rdy, e_rdy);
  end

  logic [15:0] sm, sl;
  int dn, dlast, qvc, rdc, bsy_low;

  initial begin
    #1 RST = 1'b1;
    @(negedge CLK);
    chk("ready_in_reset", msb_rdy, 1'b0);
    chk("q0_in_reset", msb_q0, 1'b1);
    cyc();
    cyc();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_q0", msb_q0, 1'b1);
    chk("rst_qvalid", msb_qv, 1'b0);
    chk("rst_busy", msb_busy, 1'b0);
    chk("rst_done", msb_done, 1'b0);
    chk("rst_ready", msb_rdy, 1'b1);
    cyc();

    // A5, continuous strobe
    LOAD_VALID = 1'b1; D = 8'hA5; SHIFT_EN = 1'b1;
    cyc();
    LOAD_VALID = 1'b0;
    sm = 16'h0; sl = 16'h0; dn = 0; dlast = 0; qvc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      sm[7-i] = msb_q0; sl[7-i] = lsb_q0;
      if (msb_done) dn++;
      if (msb_qv) qvc++;
      if (i == 7) dlast = int'(msb_done);
    end
    chk("a5_msb_seq", sm[7:0], 8'hA5);
    chk("a5_lsb_seq", sl[7:0], 8'hA5);
    chk("a5_done_count", dn, 1);
    chk("a5_done_on_8th", dlast, 1);
    chk("a5_qvalid_count", qvc, 8);
    @(negedge CLK);
    chk("a5_after_q0", msb_q0, 1'b1);
    chk("a5_after_qvalid", msb_qv, 1'b0);
    chk("a5_after_ready", msb_rdy, 1'b1);
    cyc();

    // C4, bit order comparison
    LOAD_VALID = 1'b1; D = 8'hC4;
    cyc();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      sm[7-i] = msb_q0; sl[7-i] = lsb_q0;
    end
    chk("c4_msb_seq", sm[7:0], 8'hC4);
    chk("c4_lsb_seq", sl[7:0], 8'h23);
    cyc();
    cyc();

    // 81 with strobe every other cycle
    LOAD_VALID = 1'b1; D = 8'h81; SHIFT_EN = 1'b0;
    cyc();
    LOAD_VALID = 1'b0;
    dn = 0; qvc = 0; sm = 16'h0;
    for (int i = 0; i < 20; i++) begin
      SHIFT_EN = (i % 2 == 1);
      @(negedge CLK);
      if (msb_done) dn++;
      if (msb_qv) begin
        sm[15-qvc] = msb_q0;
        qvc++;
      end
      cyc();
    end
    chk("half_rate_qvalid_cycles", qvc, 16);
    chk("half_rate_done_count", dn, 1);
    chk("half_rate_seq", sm, 16'hC003);
    SHIFT_EN = 1'b1;

    // 0F then F0 streamed back to back
    LOAD_VALID = 1'b1; D = 8'h0F;
    cyc();
    D = 8'hF0;
    rdc = 0; bsy_low = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      sm[15-i] = msb_q0;
      if (msb_rdy) rdc++;
      if (!msb_busy) bsy_low++;
      cyc();
      if (i == 7) LOAD_VALID = 1'b0;
    end
    chk("b2b_seq", sm, 16'h0FF0);
    chk("b2b_ready_count", rdc, 2);
    chk("b2b_busy_drops", bsy_low, 0);
    cyc();

    // 3C offered during bit 3 of 5A
    LOAD_VALID = 1'b1; D = 8'h5A;
    cyc();
    LOAD_VALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 3) begin
        LOAD_VALID = 1'b1; D = 8'h3C;
      end
      @(negedge CLK);
      sm[15-i] = msb_q0;
      if (i >= 3 && i < 7) chk("midword_ready_low", msb_rdy, 1'b0);
      if (i == 7) chk("midword_ready_at_done", msb_rdy, 1'b1);
      cyc();
      if (i == 7) LOAD_VALID = 1'b0;
    end
    chk("midword_seq", sm, 16'h5A3C);
    cyc();

    // Asynchronous reset after 3 bits of FF
    LOAD_VALID = 1'b1; D = 8'hFF;
    cyc();
    LOAD_VALID = 1'b0;
    cyc(); cyc(); cyc();
    #2 RST = 1'b1;
    #1;
    chk("async_rst_q0", msb_q0, 1'b1);
    chk("async_rst_qvalid", msb_qv, 1'b0);
    chk("async_rst_ready", msb_rdy, 1'b0);
    cyc();
    RST = 1'b0;
    LOAD_VALID = 1'b1; D = 8'h00;
    cyc();
    LOAD_VALID = 1'b0;
    sm = 16'hFFFF; qvc = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      sm[7-i] = msb_q0; sl[7-i] = lsb_q0;
      if (msb_qv) qvc++;
    end
    chk("post_rst_msb_zeros", sm[7:0], 8'h00);
    chk("post_rst_lsb_zeros", sl[7:0], 8'h00);
    chk("post_rst_qvalid", qvc, 8);
    cyc();
    cyc();

    // Randomised traffic; the source holds an offered word until it is taken
    for (int n = 0; n < 400; n++) begin
      if (!LOAD_VALID || mdl_acc) begin
        LOAD_VALID = ($urandom_range(0, 2) != 0);
        D = 8'($urandom);
      end
      SHIFT_EN = ($urandom_range(0, 3) != 0);
      cyc();
    end
    LOAD_VALID = 1'b0;
    SHIFT_EN = 1'b1;
    repeat (12) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out shift register. It is the successor to the fixed 3-bit PISO and adds configurable width, a configurable bit order, a valid/ready load handshake, a bit-rate enable, framing outputs and back-to-back word streaming. It sits between a parallel word source and a single-wire serial sink, for example a serial link transmitter or an LED/DAC shift chain.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
LSB_FIRST, 0, bit order: 0 shifts out D[WIDTH-1] first, 1 shifts out D[0] first.
IDLE_LEVEL, 1'b1, value driven on Q0 when no word is being shifted.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RST  input  1  reset; asynchronous, active-high.
LOAD_VALID  input  1  source presents a word on D.
LOAD_READY  output  1  block accepts D this cycle.
D  input  WIDTH  parallel word; sampled only on a handshake.
SHIFT_EN  input  1  bit-rate strobe; advances one bit per cycle in which it is high.
Q0  output  1  serial data out.
Q_VALID  output  1  Q0 carries a data bit.
BUSY  output  1  a word is in flight.
DONE  output  1  last bit of the word is consumed this cycle.

Behaviour:
- Reset (RST high, asynchronous):
  - state = IDLE; shift register = 0; bit counter = 0.
  - Q0 = IDLE_LEVEL; Q_VALID = 0; BUSY = 0; DONE = 0.
  - LOAD_READY is forced to 0 while RST is high.
- Internal state:
  - shift register of WIDTH bits.
  - bit counter of $clog2(WIDTH) bits.
  - 2-state FSM: IDLE, SHIFT.
- IDLE:
  - LOAD_READY = 1; Q0 = IDLE_LEVEL; Q_VALID = 0; BUSY = 0.
  - LOAD_VALID=1: capture D, clear counter, go to SHIFT on the next edge.
  - SHIFT_EN has no effect in IDLE.
- SHIFT:
  - Q_VALID = 1; BUSY = 1.
  - Q0 = shreg[WIDTH-1] when LSB_FIRST=0, shreg[0] when LSB_FIRST=1. Q0 is a combinational select of registered state, so the first bit appears the cycle after the handshake.
  - On each edge with SHIFT_EN=1: shift toward the output end, fill the vacated bit with 0, increment the counter.
  - SHIFT_EN=0: register, counter and Q0 hold.
- Last bit (SHIFT, counter == WIDTH-1, SHIFT_EN=1):
  - DONE = 1 for exactly that cycle (combinational).
  - LOAD_READY = 1 in the same cycle.
  - LOAD_VALID=1 as well: load the new word, clear the counter, stay in SHIFT. No idle bit between words.
  - LOAD_VALID=0: return to IDLE.
- LOAD_READY = (state==IDLE) OR (last-bit condition), and 0 during reset.
- Words offered outside LOAD_READY are not accepted.
  - Source must hold LOAD_VALID and D stable until the handshake.
  - D changes while shifting have no effect.
- Latency: handshake at edge N gives the first bit on Q0 after edge N. The word occupies exactly WIDTH SHIFT_EN strobes.
- Counter never exceeds WIDTH-1; it wraps to 0 only through a load.
- Reset mid-word: the word is discarded immediately. After RST falls the block is in IDLE, and the next load starts from the first bit.

Test Plan:
- WIDTH=8, LSB_FIRST=0, SHIFT_EN tied 1, load 8'hA5 -> Q0 = 1,0,1,0,0,1,0,1 over 8 cycles with Q_VALID=1. DONE high on the 8th cycle only, then Q0=1, Q_VALID=0, LOAD_READY=1.
- LSB_FIRST=1, load 8'hC4 -> Q0 = 0,0,1,0,0,0,1,1.
- SHIFT_EN high every other cycle, load 8'h81 -> each bit held 2 cycles, 16 cycles total, DONE asserted once.
- LOAD_VALID held with 8'h0F then 8'hF0 -> 16 contiguous bits 0000111111110000. BUSY never drops, LOAD_READY high only on the two DONE cycles.
- Assert LOAD_VALID with 8'h3C during bit 3 of a word -> LOAD_READY=0 until that word's DONE cycle, then 8'h3C is accepted and follows without a gap.
- RST pulsed asynchronously after 3 bits of 8'hFF -> Q0=1 (IDLE_LEVEL) and Q_VALID=0 without waiting for a clock edge. After release, loading 8'h00 gives 8 zeros with no leftover 1s.
